// File: rtl/spi_flash_arbiter.sv
// Round-robin sequencer sharing the SPI flash word engine between two requesters.
// Each grant issues one READ command word, then streams N data words under a held chip-select.
module spi_flash_arbiter #(
    parameter logic [7:0]  READ_OPCODE    = 8'h03,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [23:0] req_addr0,
    input  logic [23:0] req_len0,
    input  logic [23:0] req_addr1,
    input  logic [23:0] req_len1,
    output logic [1:0]  grant,
    output logic [31:0] rd_data,
    output logic [1:0]  rd_valid,
    output logic [1:0]  done,
    output logic        error,
    output logic        eng_start,
    output logic [31:0] eng_wdata,
    output logic        eng_hold_ss,
    input  logic        eng_busy,
    input  logic        eng_done,
    input  logic [31:0] eng_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT,
        S_DATA,
        S_FINISH,
        S_ABORT
    } state_e;

    localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [23:0] addr_q, addr_d;
    logic [23:0] cnt_q, cnt_d;
    logic        data_phase_q, data_phase_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [1:0]  rd_valid_q, rd_valid_d;
    logic [1:0]  done_q, done_d;
    logic        error_q, error_d;
    logic        eng_start_q, eng_start_d;
    logic [31:0] eng_wdata_q, eng_wdata_d;
    logic        eng_hold_q, eng_hold_d;
    logic        win;

    // last_grant_q holds the index of the previous owner; the other one wins a tie
    always_comb begin
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_grant_q;
            default: win = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        data_phase_d = data_phase_q;
        tmo_d        = tmo_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = '0;
        done_d       = '0;
        error_d      = 1'b0;
        eng_start_d  = 1'b0;
        eng_wdata_d  = eng_wdata_q;
        eng_hold_d   = eng_hold_q;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    addr_d  = win ? req_addr1 : req_addr0;
                    cnt_d   = win ? req_len1 : req_len0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (!eng_busy) begin
                    eng_start_d  = 1'b1;
                    eng_wdata_d  = {READ_OPCODE, addr_q};
                    eng_hold_d   = (cnt_q != '0);
                    data_phase_d = 1'b0;
                    tmo_d        = '0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // eng_done wins over a timeout expiring in the same cycle
                if (eng_done) begin
                    if (data_phase_q) begin
                        rd_data_d  = eng_rdata;
                        rd_valid_d = grant_q;
                        cnt_d      = cnt_q - 24'd1;
                        state_d    = (cnt_q == 24'd1) ? S_FINISH : S_DATA;
                    end else begin
                        state_d = (cnt_q == '0) ? S_FINISH : S_DATA;
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 16'd1;
                end
            end
            S_DATA: begin
                if (!eng_busy) begin
                    eng_start_d  = 1'b1;
                    eng_wdata_d  = '0;
                    eng_hold_d   = (cnt_q != 24'd1);
                    data_phase_d = 1'b1;
                    tmo_d        = '0;
                    state_d      = S_WAIT;
                end
            end
            S_FINISH: begin
                done_d       = grant_q;
                last_grant_d = grant_q[1];
                grant_d      = '0;
                state_d      = S_IDLE;
            end
            S_ABORT: begin
                error_d      = 1'b1;
                last_grant_d = grant_q[1];
                grant_d      = '0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            cnt_q        <= '0;
            data_phase_q <= 1'b0;
            tmo_q        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= '0;
            done_q       <= '0;
            error_q      <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_wdata_q  <= '0;
            eng_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            data_phase_q <= data_phase_d;
            tmo_q        <= tmo_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            done_q       <= done_d;
            error_q      <= error_d;
            eng_start_q  <= eng_start_d;
            eng_wdata_q  <= eng_wdata_d;
            eng_hold_q   <= eng_hold_d;
        end
    end

    assign grant       = grant_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign done        = done_q;
    assign error       = error_q;
    assign eng_start   = eng_start_q;
    assign eng_wdata   = eng_wdata_q;
    assign eng_hold_ss = eng_hold_q;

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Sequencer and arbiter in front of the word-level SPI flash shift engine.
- Shares the engine between two requesters: req 0 = channel bitstream programmer, req 1 = slow-control flash reader.
- For each granted request it issues a READ command word {opcode, 24-bit address}, then streams N 32-bit data words under one continuous chip-select.
- Returns each data word to the owning requester and signals completion, or an error on timeout.

Parameters:
- READ_OPCODE, 8'h03, flash read opcode placed in bits [31:24] of the command word.
- TIMEOUT_CYCLES, 16'd4096, maximum clk cycles to wait for eng_done after an eng_start.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  request level per requester; sampled only in IDLE.
- req_addr0  in  24  flash start byte address, requester 0.
- req_len0  in  24  number of 32-bit data words, requester 0.
- req_addr1  in  24  flash start byte address, requester 1.
- req_len1  in  24  number of 32-bit data words, requester 1.
- grant  out  2  one-hot owner of the engine; held for the whole transaction.
- rd_data  out  32  data word returned from the flash.
- rd_valid  out  2  one-cycle pulse on the granted bit when rd_data is valid.
- done  out  2  one-cycle pulse on the granted bit at successful end of a transaction.
- error  out  1  one-cycle pulse when a transaction is aborted by timeout.
- eng_start  out  1  one-cycle pulse that starts one 32-bit engine transfer.
- eng_wdata  out  32  word the engine shifts out on MOSI.
- eng_hold_ss  out  1  1 = keep chip-select asserted after this word; 0 = release.
- eng_busy  in  1  engine is shifting.
- eng_done  in  1  one-cycle pulse at the end of an engine transfer.
- eng_rdata  in  32  word shifted in from MISO; valid with eng_done.

Behaviour:
- Async reset (reset_n=0): all outputs 0, state=IDLE, last_grant=1 (so req 0 wins first), counters 0.
- State machine:
  - IDLE: if req!=0, pick the winner, latch its addr/len into the internal copy and the word counter, set grant (registered), go to CMD.
  - CMD: once eng_busy=0, pulse eng_start with eng_wdata={READ_OPCODE, addr}; eng_hold_ss=1 if len!=0, else 0. Go to WAIT.
  - WAIT: count cycles.
    - On eng_done in a data phase: drive rd_data=eng_rdata and pulse rd_valid[grant] in the next cycle, then decrement the counter.
    - Counter reaches 0 after a data word, or the command had len=0: go to FINISH.
    - Otherwise go to DATA.
    - Timeout reached before eng_done: go to ABORT.
  - DATA: once eng_busy=0, pulse eng_start with eng_wdata=32'h0; eng_hold_ss=1 unless this is the last word (counter==1). Go to WAIT.
  - FINISH: pulse done[grant], record last_grant, clear grant, go to IDLE.
  - ABORT: pulse error, record last_grant, clear grant, go to IDLE. No further eng_start. The engine releases chip-select itself only when eng_hold_ss was 0, so the abort path issues no extra word.
- Arbitration: round-robin.
  - Only one requester high: it wins.
  - Both high: the one not in last_grant wins.
  - Evaluated only in IDLE; no preemption.
- Latency:
  - req rise in IDLE -> grant at cycle +1 -> eng_start at cycle +2 (engine idle).
  - eng_done -> rd_valid at +1.
  - Final eng_done -> done at +2.
  - Minimum one IDLE cycle between transactions.
- Timing rules:
  - Timeout counter: 16-bit, cleared on every eng_start, saturates.
  - eng_done arriving on the same cycle the timeout expires counts as success.
- Input capture:
  - req deassertion mid-transaction is ignored; the transaction runs to completion.
  - addr/len changes after grant are ignored (latched copies used).
- Address: never incremented; flash streams sequentially under held chip-select. 24-bit len, maximum 16,777,215 words.
- eng_done outside WAIT is ignored.
- Reset asserted mid-transaction: immediate return to reset values; no done or error pulse.

Test Plan:
- req=01, addr0=24'h123456, len0=3, engine returns A1,A2,A3:
  - eng_wdata sequence 0x03123456, 0, 0, 0.
  - eng_hold_ss 1,1,1,0.
  - three rd_valid[0] pulses with A1..A3, then one done[0] pulse.
- req=11 held continuously from reset, len=1 each: grant order 01,10,01,10; done alternates [0],[1]; never two consecutive grants to the same requester.
- len1=0, req=10: single eng_start with eng_hold_ss=0, no rd_valid, done[1] two cycles after eng_done.
- TIMEOUT_CYCLES=16, eng_done never returned: error pulse 16–17 cycles after eng_start, grant cleared, no done, next request accepted.
- Assert reset_n=0 during the second data word of len=5: all outputs 0 asynchronously; after release, req=01 restarts with command word at cycle +2 and last_grant favouring requester 0.
- req0 dropped after grant with len0=2: both words still issued and returned, done[0] pulses.
